// File: rtl/led_fader.sv
// LED fader: synchronises the blinker level and ramps an 8-bit PWM duty up on rising
// edges and down on falling edges, driving the active-low LED bank.
module led_fader #(
    parameter int PWM_DIV  = 94,
    parameter int FADE_DIV = 23529
) (
    input  logic       CLK_24MHZ,
    input  logic       reset,
    input  logic       blink_in,
    input  logic [7:0] led_mask,
    output logic [7:0] LED,
    output logic       busy
);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        UP   = 2'd1,
        ON   = 2'd2,
        DOWN = 2'd3
    } state_t;

    // A width of zero is illegal, so PWM_DIV == 1 still gets a 1-bit prescaler.
    localparam int            PRE_W     = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(PWM_DIV - 1);
    localparam logic [24:0]      FADE_LAST = 25'(FADE_DIV - 1);

    logic             sync1, sync2, prev;
    logic             rise, fall;
    logic [PRE_W-1:0] pwm_pre;
    logic [7:0]       pwm_cnt;
    logic             pwm_on;
    logic [24:0]      fade_cnt;
    logic             tick;
    logic             fade_clear;
    state_t           state, next_state;
    logic [7:0]       duty, next_duty;

    always_ff @(posedge CLK_24MHZ) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= blink_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;
    assign fall = ~sync2 & prev;

    always_ff @(posedge CLK_24MHZ) begin
        if (reset) begin
            pwm_pre <= '0;
            pwm_cnt <= 8'd0;
        end else if (pwm_pre == PRE_LAST) begin
            pwm_pre <= '0;
            pwm_cnt <= pwm_cnt + 8'd1;
        end else begin
            pwm_pre <= pwm_pre + 1'b1;
        end
    end

    assign pwm_on = (duty == 8'hFF) | (pwm_cnt < duty);
    assign tick   = (fade_cnt == FADE_LAST);

    // Restarting the prescaler on entry to a ramp makes the first step land a full
    // FADE_DIV cycles after the edge, independent of where the free count was.
    always_ff @(posedge CLK_24MHZ) begin
        if (reset || fade_clear || tick) begin
            fade_cnt <= 25'd0;
        end else begin
            fade_cnt <= fade_cnt + 25'd1;
        end
    end

    always_ff @(posedge CLK_24MHZ) begin
        if (reset) begin
            state <= OFF;
            duty  <= 8'd0;
        end else begin
            state <= next_state;
            duty  <= next_duty;
        end
    end

    // Reversals are tested before the tick so a coincident step is dropped, and the
    // end-of-ramp check looks at the post-step duty so ON/OFF coincide with 255/0.
    always_comb begin
        next_state = state;
        next_duty  = duty;
        fade_clear = 1'b0;
        case (state)
            OFF: begin
                if (rise) next_state = UP;
            end
            UP: begin
                if (fall) begin
                    next_state = DOWN;
                end else begin
                    if (tick && duty != 8'hFF) next_duty = duty + 8'd1;
                    if (next_duty == 8'hFF) next_state = ON;
                end
            end
            ON: begin
                if (fall) next_state = DOWN;
            end
            DOWN: begin
                if (rise) begin
                    next_state = UP;
                end else begin
                    if (tick && duty != 8'd0) next_duty = duty - 8'd1;
                    if (next_duty == 8'd0) next_state = OFF;
                end
            end
            default: next_state = OFF;
        endcase
        fade_clear = (next_state != state) && ((next_state == UP) || (next_state == DOWN));
    end

    always_ff @(posedge CLK_24MHZ) begin
        if (reset) begin
            LED  <= 8'hFF;
            busy <= 1'b0;
        end else begin
            LED  <= ~(led_mask & {8{pwm_on}});
            busy <= (next_state == UP) || (next_state == DOWN);
        end
    end

endmodule

// File: tb/tb_led_fader.sv
// Directed bench for led_fader: a fast-fade instance for ramp/reversal/glitch/reset
// timing and a slower-fade instance for measuring the PWM duty cycle.
module tb_led_fader;

    logic       clk;
    logic       reset;
    logic       blink_a, blink_b;
    logic [7:0] mask_a, mask_b;
    logic [7:0] led_a, led_b;
    logic       busy_a, busy_b;

    int vectors;
    int miscompares;

    typedef struct {
        logic [7:0] mask;
        logic [7:0] exp_led;
        logic       exp_busy;
    } vec_t;

    vec_t vecs[5];

    led_fader #(.PWM_DIV(1), .FADE_DIV(4)) dut_a (
        .CLK_24MHZ(clk),
        .reset    (reset),
        .blink_in (blink_a),
        .led_mask (mask_a),
        .LED      (led_a),
        .busy     (busy_a)
    );

    led_fader #(.PWM_DIV(1), .FADE_DIV(300)) dut_b (
        .CLK_24MHZ(clk),
        .reset    (reset),
        .blink_in (blink_b),
        .led_mask (mask_b),
        .LED      (led_b),
        .busy     (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic blink, input logic [7:0] mask);
        blink_a = blink;
        mask_a  = mask;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        int low_cnt;
        int busy_cnt;
        logic hi_ok;

        vectors     = 0;
        miscompares = 0;
        vecs[0] = '{mask: 8'h00, exp_led: 8'hFF, exp_busy: 1'b0};
        vecs[1] = '{mask: 8'hA5, exp_led: 8'h5A, exp_busy: 1'b0};
        vecs[2] = '{mask: 8'h0F, exp_led: 8'hF0, exp_busy: 1'b0};
        vecs[3] = '{mask: 8'h80, exp_led: 8'h7F, exp_busy: 1'b0};
        vecs[4] = '{mask: 8'hFF, exp_led: 8'h00, exp_busy: 1'b0};

        reset   = 1'b1;
        blink_a = 1'b0;
        blink_b = 1'b0;
        mask_a  = 8'hFF;
        mask_b  = 8'h0F;

        // Reset held for 5 edges, then 100 idle cycles.
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            checkOutput("reset_led", led_a, 8'hFF);
            checkOutput("reset_busy", busy_a, 1'b0);
        end
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycles(1);
            checkOutput("idle_led", led_a, 8'hFF);
            checkOutput("idle_busy", busy_a, 1'b0);
        end

        // Full ramp up; edge k is the first edge sampling blink high.
        applyStimulus(1'b1, 8'hFF);
        cycles(1);
        cycles(1);
        checkOutput("ramp_busy_k1", busy_a, 1'b0);
        cycles(1);
        checkOutput("ramp_busy_k2", busy_a, 1'b1);
        checkOutput("ramp_duty_k2", dut_a.duty, 8'd0);
        cycles(3);
        checkOutput("ramp_duty_k5", dut_a.duty, 8'd0);
        cycles(1);
        checkOutput("ramp_duty_k6", dut_a.duty, 8'd1);
        cycles(1015);
        checkOutput("ramp_busy_k1021", busy_a, 1'b1);
        checkOutput("ramp_duty_k1021", dut_a.duty, 8'd254);
        cycles(1);
        checkOutput("ramp_busy_k1022", busy_a, 1'b0);
        checkOutput("ramp_duty_k1022", dut_a.duty, 8'd255);
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            checkOutput("on_led", led_a, 8'h00);
        end

        // Mask table applied while fully lit.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, vecs[i].mask);
            cycles(1);
            checkOutput($sformatf("mask_led_%0d", i), led_a, vecs[i].exp_led);
            checkOutput($sformatf("mask_busy_%0d", i), busy_a, vecs[i].exp_busy);
        end

        // Full ramp down back to OFF.
        applyStimulus(1'b0, 8'hFF);
        cycles(1);
        cycles(2);
        checkOutput("down_busy_k2", busy_a, 1'b1);
        cycles(1027);
        checkOutput("down_busy_end", busy_a, 1'b0);
        checkOutput("down_duty_end", dut_a.duty, 8'd0);
        checkOutput("down_led_end", led_a, 8'hFF);

        // Reversal at duty 100.
        applyStimulus(1'b1, 8'hFF);
        cycles(1);
        cycles(402);
        checkOutput("rev_duty100", dut_a.duty, 8'd100);
        applyStimulus(1'b0, 8'hFF);
        cycles(1);
        checkOutput("rev_busy_k0", busy_a, 1'b1);
        cycles(2);
        checkOutput("rev_busy_k2", busy_a, 1'b1);
        checkOutput("rev_duty_k2", dut_a.duty, 8'd100);
        cycles(3);
        checkOutput("rev_duty_k5", dut_a.duty, 8'd100);
        cycles(1);
        checkOutput("rev_duty_k6", dut_a.duty, 8'd99);
        cycles(395);
        checkOutput("rev_duty_k401", dut_a.duty, 8'd1);
        checkOutput("rev_busy_k401", busy_a, 1'b1);
        cycles(1);
        checkOutput("rev_duty_k402", dut_a.duty, 8'd0);
        checkOutput("rev_busy_k402", busy_a, 1'b0);
        cycles(1);
        checkOutput("rev_led_k403", led_a, 8'hFF);

        // One-cycle glitch in OFF.
        cycles(5);
        busy_cnt = 0;
        applyStimulus(1'b1, 8'hFF);
        cycles(1);
        applyStimulus(1'b0, 8'hFF);
        for (int i = 1; i <= 8; i++) begin
            cycles(1);
            if (busy_a === 1'b1) busy_cnt++;
            checkOutput($sformatf("glitch_busy_k%0d", i), busy_a,
                        (i == 2 || i == 3) ? 1'b1 : 1'b0);
            checkOutput("glitch_led", led_a, 8'hFF);
        end
        checkOutput("glitch_busy_cycles", busy_cnt, 2);
        checkOutput("glitch_duty", dut_a.duty, 8'd0);

        // Reset pulse mid-ramp with blink held high.
        applyStimulus(1'b1, 8'hFF);
        cycles(1);
        cycles(202);
        checkOutput("rst_duty50", dut_a.duty, 8'd50);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        checkOutput("rst_duty0", dut_a.duty, 8'd0);
        checkOutput("rst_led", led_a, 8'hFF);
        checkOutput("rst_busy", busy_a, 1'b0);
        cycles(2);
        checkOutput("rst_busy_r2", busy_a, 1'b0);
        cycles(1);
        checkOutput("rst_busy_r3", busy_a, 1'b1);
        checkOutput("rst_duty_r3", dut_a.duty, 8'd0);
        cycles(3);
        checkOutput("rst_duty_r6", dut_a.duty, 8'd0);
        cycles(1);
        checkOutput("rst_duty_r7", dut_a.duty, 8'd1);

        // PWM duty measurement on the slow instance at duty 64, mask 0F.
        blink_b = 1'b1;
        cycles(1);
        cycles(2 + 64 * 300);
        checkOutput("pwm_duty64", dut_b.duty, 8'd64);
        low_cnt = 0;
        hi_ok   = 1'b1;
        for (int i = 0; i < 256; i++) begin
            cycles(1);
            if (led_b[0] === 1'b0) low_cnt++;
            if (led_b[7:4] !== 4'hF) hi_ok = 1'b0;
        end
        checkOutput("pwm_low_cycles", low_cnt, 64);
        checkOutput("pwm_masked_high", hi_ok, 1'b1);
        checkOutput("pwm_duty_hold", dut_b.duty, 8'd64);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
